// File: rtl/me_wb_skid_pipe_pkg.sv
// Shared constants and types for the MEM->WB skid pipeline register.
package me_wb_skid_pipe_pkg;

    // Default geometry: one writeback lane, 32 registers of 32 bits.
    localparam int WB_LANES   = 1;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // Value driven on a write enable that must not write.
    localparam logic WRITE_DISABLE = 1'b0;

    // Occupancy of the stage, encoded as {main_v, skid_v}.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b10,
        OCC_FULL  = 2'b11
    } occ_e;

endpackage

// File: rtl/me_wb_skid_pipe_if.sv
// MEM->WB bus bundle: input handshake, WB handshake, forwarding lookup and flush.
interface me_wb_skid_pipe_if
    import me_wb_skid_pipe_pkg::*;
#(
    parameter int LANES  = WB_LANES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES-1:0]          in_w_en;
    logic [LANES*ADDR_W-1:0]   in_w_addr;
    logic [LANES*DATA_W-1:0]   in_w_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES-1:0]          wb_w_en;
    logic [LANES*ADDR_W-1:0]   wb_w_addr;
    logic [LANES*DATA_W-1:0]   wb_w_data;
    logic [ADDR_W-1:0]         fwd_addr;
    logic                      fwd_hit;
    logic [DATA_W-1:0]         fwd_data;

    // Pipeline-register side.
    modport slave (
        input  flush, in_valid, in_w_en, in_w_addr, in_w_data, out_ready, fwd_addr,
        output in_ready, out_valid, wb_w_en, wb_w_addr, wb_w_data, fwd_hit, fwd_data
    );

    // MEM / WB / hazard-unit side.
    modport master (
        output flush, in_valid, in_w_en, in_w_addr, in_w_data, out_ready, fwd_addr,
        input  in_ready, out_valid, wb_w_en, wb_w_addr, wb_w_data, fwd_hit, fwd_data
    );
endinterface

// File: rtl/me_wb_skid_pipe_slot.sv
// One writeback stage slot: valid bit plus LANES x {en, addr, data}.
// Lanes targeting r0 are stored with their write enable cleared.
module me_wb_skid_pipe_slot
    import me_wb_skid_pipe_pkg::*;
#(
    parameter int LANES  = WB_LANES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [LANES-1:0]        ld_en,
    input  logic [LANES*ADDR_W-1:0] ld_addr,
    input  logic [LANES*DATA_W-1:0] ld_data,
    output logic                    valid,
    output logic [LANES-1:0]        w_en,
    output logic [LANES*ADDR_W-1:0] w_addr,
    output logic [LANES*DATA_W-1:0] w_data
);
    logic                    valid_reg;
    logic [LANES-1:0]        en_reg;
    logic [LANES*ADDR_W-1:0] addr_reg;
    logic [LANES*DATA_W-1:0] data_reg;
    logic [LANES-1:0]        gated_en;

    // r0 is hardwired zero, so a write to it is turned into a no-op here.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_gate
            assign gated_en[gi] = ld_en[gi] & (ld_addr[gi*ADDR_W +: ADDR_W] != '0);
        end
    endgenerate

    // Slot register: clear wins over load so flush never lets an entry through.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_reg <= 1'b0;
            en_reg    <= {LANES{WRITE_DISABLE}};
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            en_reg    <= gated_en;
            addr_reg  <= ld_addr;
            data_reg  <= ld_data;
        end
    end

    assign valid  = valid_reg;
    assign w_en   = en_reg;
    assign w_addr = addr_reg;
    assign w_data = data_reg;
endmodule

// File: rtl/me_wb_skid_pipe.sv
// MEM->WB pipeline register with valid/ready handshake, optional skid slot,
// flush, r0 write suppression and a forwarding lookup over held entries.
module me_wb_skid_pipe
    import me_wb_skid_pipe_pkg::*;
#(
    parameter int LANES   = WB_LANES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    me_wb_skid_pipe_if.slave   bus
);
    logic                    main_v, skid_v;
    logic [LANES-1:0]        main_en, skid_en;
    logic [LANES*ADDR_W-1:0] main_addr, skid_addr;
    logic [LANES*DATA_W-1:0] main_data, skid_data;

    logic                    main_load, main_clear, main_from_skid;
    logic                    skid_load, skid_clear;
    logic [LANES-1:0]        main_ld_en;
    logic [LANES*ADDR_W-1:0] main_ld_addr;
    logic [LANES*DATA_W-1:0] main_ld_data;

    logic   in_ready_w;
    logic   accept, drain;
    occ_e   occ;

    assign accept = bus.in_valid & in_ready_w & ~bus.flush;
    assign drain  = main_v & bus.out_ready;
    assign occ    = occ_e'({main_v, skid_v});

    // Main slot refills either from the skid slot (older) or from the MEM input.
    assign main_ld_en   = main_from_skid ? skid_en   : bus.in_w_en;
    assign main_ld_addr = main_from_skid ? skid_addr : bus.in_w_addr;
    assign main_ld_data = main_from_skid ? skid_data : bus.in_w_data;

    // Slot load/clear decisions from occupancy and this cycle's handshakes.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (bus.flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (SKID_EN) begin
            case (occ)
                OCC_EMPTY: main_load = accept;
                OCC_ONE: begin
                    if (drain) begin
                        main_load  = accept;
                        main_clear = ~accept;
                    end else begin
                        skid_load  = accept;
                    end
                end
                OCC_FULL: begin
                    if (drain) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_load      = accept;
                        skid_clear     = ~accept;
                    end
                end
                default: begin
                    // Skid without main cannot arise; recover to empty.
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end else begin
            main_load  = accept;
            main_clear = drain & ~accept;
        end
    end

    me_wb_skid_pipe_slot #(
        .LANES (LANES),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .clear  (main_clear),
        .load   (main_load),
        .ld_en  (main_ld_en),
        .ld_addr(main_ld_addr),
        .ld_data(main_ld_data),
        .valid  (main_v),
        .w_en   (main_en),
        .w_addr (main_addr),
        .w_data (main_data)
    );

    generate
        if (SKID_EN) begin : g_skid
            me_wb_skid_pipe_slot #(
                .LANES (LANES),
                .ADDR_W(ADDR_W),
                .DATA_W(DATA_W)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .clear  (skid_clear),
                .load   (skid_load),
                .ld_en  (bus.in_w_en),
                .ld_addr(bus.in_w_addr),
                .ld_data(bus.in_w_data),
                .valid  (skid_v),
                .w_en   (skid_en),
                .w_addr (skid_addr),
                .w_data (skid_data)
            );
            // Ready depends only on registered state, breaking the out_ready path.
            assign in_ready_w = ~skid_v;
        end else begin : g_no_skid
            assign skid_v     = 1'b0;
            assign skid_en    = '0;
            assign skid_addr  = '0;
            assign skid_data  = '0;
            assign in_ready_w = ~main_v | bus.out_ready;
        end
    endgenerate

    // Per-lane forwarding matches for both held entries.
    logic [LANES-1:0] main_match, skid_match;
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_fwd
            assign main_match[gi] = main_v & main_en[gi] &
                                    (main_addr[gi*ADDR_W +: ADDR_W] == bus.fwd_addr);
            assign skid_match[gi] = skid_v & skid_en[gi] &
                                    (skid_addr[gi*ADDR_W +: ADDR_W] == bus.fwd_addr);
        end
    endgenerate

    // Youngest write wins: later lanes override earlier, skid overrides main.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (main_match[i]) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = main_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (skid_match[i]) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = skid_data[i*DATA_W +: DATA_W];
            end
        end
        if (bus.fwd_addr == '0) begin
            bus.fwd_hit  = 1'b0;
            bus.fwd_data = '0;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = main_v;
    assign bus.wb_w_en   = main_v ? main_en   : {LANES{WRITE_DISABLE}};
    assign bus.wb_w_addr = main_v ? main_addr : '0;
    assign bus.wb_w_data = main_v ? main_data : '0;
endmodule

// File: tb/tb_me_wb_skid_pipe.sv
// Scoreboard bench for me_wb_skid_pipe (LANES=2, skid enabled).
// The reference model is a FIFO of accepted entries: head is what WB sees,
// size tells occupancy, and forwarding is the last matching write in age order.
module tb_me_wb_skid_pipe;
    localparam int LANES  = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct {
        logic [LANES-1:0]        en;
        logic [LANES*ADDR_W-1:0] addr;
        logic [LANES*DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_wb_skid_pipe_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    me_wb_skid_pipe #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SKID_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ent_t exp_q[$];
    int   pending = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   mon_on  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Forwarding reference: scan entries oldest->youngest, lanes low->high; last match wins.
    function automatic void fwd_model(input logic [ADDR_W-1:0] a, input int held,
                                      output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int j = 0; j < held; j++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (exp_q[j].en[l] && exp_q[j].addr[l*ADDR_W +: ADDR_W] == a) begin
                        hit = 1'b1;
                        d   = exp_q[j].data[l*DATA_W +: DATA_W];
                    end
                end
            end
        end
    endfunction

    // Monitor: compare DUT outputs with the model, then retire or flush entries.
    always @(negedge clk) begin
        if (mon_on) begin
            int                held;
            logic              exp_v;
            logic              f_hit;
            logic [DATA_W-1:0] f_data;
            held  = exp_q.size() - pending;
            exp_v = (held > 0);
            chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
            chk("in_ready",  64'(bus.in_ready),  64'(held < 2));
            chk("wb_w_en",   64'(bus.wb_w_en),   exp_v ? 64'(exp_q[0].en)   : 64'd0);
            chk("wb_w_addr", 64'(bus.wb_w_addr), exp_v ? 64'(exp_q[0].addr) : 64'd0);
            chk("wb_w_data", 64'(bus.wb_w_data), exp_v ? 64'(exp_q[0].data) : 64'd0);
            fwd_model(bus.fwd_addr, held, f_hit, f_data);
            chk("fwd_hit",  64'(bus.fwd_hit),  64'(f_hit));
            chk("fwd_data", 64'(bus.fwd_data), 64'(f_data));
            if (bus.out_valid && bus.out_ready && exp_v)
                $display("drain en=%b addr=%h data=%h", exp_q[0].en, exp_q[0].addr, exp_q[0].data);
            if (rst || bus.flush) begin
                if (bus.flush) $display("flush held=%0d", held);
                exp_q.delete();
            end else if (bus.out_valid && bus.out_ready && exp_v) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Driver: one cycle of stimulus; the expected entry is queued when accepted.
    task automatic step(input logic iv, input logic [LANES-1:0] en,
                        input logic [LANES*ADDR_W-1:0] a, input logic [LANES*DATA_W-1:0] d,
                        input logic ordy, input logic fl, input logic [ADDR_W-1:0] fa);
        ent_t e;
        bus.in_valid  = iv;
        bus.in_w_en   = en;
        bus.in_w_addr = a;
        bus.in_w_data = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.fwd_addr  = fa;
        pending = 0;
        if (iv && bus.in_ready && !fl && !rst) begin
            for (int l = 0; l < LANES; l++)
                e.en[l] = en[l] && (a[l*ADDR_W +: ADDR_W] != '0);
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
            pending = 1;
            $display("accept en=%b addr=%h data=%h", e.en, e.addr, e.data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, ordy, 1'b0, 5'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_w_en   = 2'b11;
        bus.in_w_addr = {5'd2, 5'd1};
        bus.in_w_data = {32'h2, 32'h1};
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.fwd_addr  = 5'd1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        // Reset held for three clocks with input offered: nothing may be taken.
        repeat (2) step(1'b1, 2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b1, 1'b0, 5'd1);
        rst = 1'b0;

        // Streaming with WB always ready: one per clock, in order.
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'b01, {5'd0, 5'(i + 1)}, {32'h0, 32'h10 + 32'(i)}, 1'b1, 1'b0, 5'(i));
        idle(1'b1, 2);

        // WB stalls for three clocks mid-stream: skid fills, then releases in order.
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'b01, {5'd0, 5'(i + 1)}, {32'h0, 32'h20 + 32'(i)},
                 !(i >= 2 && i < 5), 1'b0, 5'd3);
        idle(1'b1, 3);

        // r0 lane gating: lane0 to r0 is suppressed, lane1 to r3 writes.
        step(1'b1, 2'b11, {5'd3, 5'd0}, {32'h33, 32'hDEAD}, 1'b1, 1'b0, 5'd3);
        idle(1'b1, 2);

        // Forwarding priority: skid (0x22) over main (0x11) for r5; r0 never hits.
        step(1'b1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h11}, 1'b0, 1'b0, 5'd5);
        step(1'b1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h22}, 1'b0, 1'b0, 5'd5);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 5'd5);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 5'd0);

        // Flush while full with input offered: everything vanishes.
        step(1'b1, 2'b11, {5'd7, 5'd6}, {32'h77, 32'h66}, 1'b0, 1'b1, 5'd7);
        idle(1'b1, 2);

        // Random traffic, stalls, flushes and lookups.
        for (int n = 0; n < 2000; n++) begin
            logic [ADDR_W-1:0] a0, a1;
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), {a1, a0},
                 {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, 5'($urandom_range(0, 7)));
        end
        idle(1'b1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
